// File: rtl/ads127x_pkg.sv
// Shared FSM state encoding, fixed ADC strap values and the frame-length sanity check.
package ads127x_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_FSYNC,
        ST_SHIFT,
        ST_LOAD
    } state_t;

    // Frame-sync mode with one DOUT line per channel.
    localparam logic [2:0] ADS_FORMAT = 3'b101;
    localparam logic [1:0] ADS_TEST   = 2'b00;
    localparam logic       ADS_SYNC_N = 1'b1;

    // FSYNC + all data bits + LOAD + at least one WAIT cycle must fit in a frame.
    function automatic bit frame_cyc_ok(input int frame_cyc, input int data_w, input int sclk_div);
        return frame_cyc >= (data_w + 1) * sclk_div + 2;
    endfunction

endpackage

// File: rtl/ads127x_sclk_gen.sv
// SCLK phase generator for SHIFT: low half then high half per bit, capture strobe on last high cycle.
// Zero-latency strobes from registered phase/bit counters; no backpressure, counters clear whenever i_en is low.
module ads127x_sclk_gen #(
    parameter int P_DATA_W   = 24,
    parameter int P_SCLK_DIV = 4
) (
    input  logic i_sysclk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_sclk,
    output logic o_capture,
    output logic o_bit_done,
    output logic o_word_done
);

    localparam int              PW       = $clog2(P_SCLK_DIV);
    localparam int              BW       = $clog2(P_DATA_W);
    localparam logic [PW-1:0]   PH_LAST  = PW'(P_SCLK_DIV - 1);
    localparam logic [PW-1:0]   PH_HALF  = PW'(P_SCLK_DIV / 2);
    localparam logic [BW-1:0]   BIT_LAST = BW'(P_DATA_W - 1);

    logic [PW-1:0] phase_q, phase_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          last_phase;

    assign last_phase = i_en && (phase_q == PH_LAST);

    always_comb begin
        phase_d = '0;
        bit_d   = '0;
        if (i_en) begin
            phase_d = last_phase ? '0 : phase_q + 1'b1;
            bit_d   = last_phase ? bit_q + 1'b1 : bit_q;
        end
    end

    always_ff @(posedge i_sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase_q <= '0;
            bit_q   <= '0;
        end else begin
            phase_q <= phase_d;
            bit_q   <= bit_d;
        end
    end

    assign o_sclk      = i_en && (phase_q >= PH_HALF);
    assign o_capture   = last_phase;
    assign o_bit_done  = last_phase;
    assign o_word_done = last_phase && (bit_q == BIT_LAST);

endmodule

// File: rtl/ads127x_frame_reader.sv
// ADS127x frame-sync reader: FSYNC/SCLK generation, parallel DOUT capture, frame out on valid/ready.
// Valid (W+1)*DIV+1 cycles after FSYNC rise; a frame loading against a stalled output is dropped and flags overrun.
module ads127x_frame_reader
    import ads127x_pkg::*;
#(
    parameter int         P_CH_NUM    = 8,
    parameter int         P_DATA_W    = 24,
    parameter int         P_SCLK_DIV  = 4,
    parameter int         P_FRAME_CYC = 512,
    parameter logic [1:0] P_ADS_MODE  = 2'b01,
    parameter logic [7:0] P_ADS_PWDN  = {8{1'b1}}
) (
    input  logic                         i_sysclk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    output logic                         o_ads_fsync,
    output logic                         o_ads_sclk,
    input  logic [P_CH_NUM-1:0]          i_ads_data,
    output logic [1:0]                   o_ads_mode,
    output logic [P_CH_NUM-1:0]          o_ads_pwdn,
    output logic [2:0]                   o_ads_format,
    output logic [1:0]                   o_ads_test,
    output logic                         o_ads_sync_n,
    output logic [P_CH_NUM*P_DATA_W-1:0] o_frame_data,
    output logic                         o_frame_valid,
    input  logic                         i_frame_ready,
    output logic [15:0]                  o_frame_seq,
    output logic                         o_overrun,
    input  logic                         i_overrun_clr,
    output logic                         o_busy
);

    localparam int                  CW         = $clog2(P_FRAME_CYC);
    localparam int                  FW         = P_CH_NUM * P_DATA_W;
    localparam logic [CW-1:0]       CNT_LAST   = CW'(P_FRAME_CYC - 1);
    localparam logic [CW-1:0]       FSYNC_LAST = CW'(P_SCLK_DIV - 1);
    localparam logic [P_CH_NUM-1:0] CH_EN      = P_ADS_PWDN[P_CH_NUM-1:0];

    if (!frame_cyc_ok(P_FRAME_CYC, P_DATA_W, P_SCLK_DIV)) begin : g_bad_cfg
        $error("P_FRAME_CYC too short for FSYNC, shift and load");
    end

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          capture, bit_done, word_done;
    logic [FW-1:0] frame_d;
    logic [FW-1:0] data_q;
    logic [15:0]   seq_q, seq_cnt_q;
    logic          valid_q, ovr_q;
    logic          load, accept, stalled;

    ads127x_sclk_gen #(
        .P_DATA_W   (P_DATA_W),
        .P_SCLK_DIV (P_SCLK_DIV)
    ) u_sclk_gen (
        .i_sysclk    (i_sysclk),
        .i_rst_n     (i_rst_n),
        .i_en        (state_q == ST_SHIFT),
        .o_sclk      (o_ads_sclk),
        .o_capture   (capture),
        .o_bit_done  (bit_done),
        .o_word_done (word_done)
    );

    // Frame counter free-runs in every active state; its wrap alone defines the FSYNC period.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!i_start) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
        end else begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            unique case (state_q)
                ST_FSYNC: if (cnt_q == FSYNC_LAST)     state_d = ST_SHIFT;
                ST_SHIFT: if (bit_done && word_done)   state_d = ST_LOAD;
                ST_LOAD:                               state_d = ST_WAIT;
                default:                               state_d = state_q;
            endcase
            if (cnt_q == CNT_LAST) state_d = ST_FSYNC;
        end
    end

    always_ff @(posedge i_sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar g = 0; g < P_CH_NUM; g++) begin : g_ch
        logic [P_DATA_W-1:0] shreg_q;

        always_ff @(posedge i_sysclk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                shreg_q <= '0;
            end else if (capture) begin
                shreg_q <= {shreg_q[P_DATA_W-2:0], i_ads_data[g]};
            end
        end

        assign frame_d[g*P_DATA_W +: P_DATA_W] = CH_EN[g] ? shreg_q : '0;
    end

    assign load    = (state_q == ST_LOAD) && i_start;
    assign accept  = valid_q && i_frame_ready;
    assign stalled = valid_q && !i_frame_ready;

    // A load replaces the presented frame only when that frame is gone or leaving this cycle.
    always_ff @(posedge i_sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            seq_q     <= '0;
            seq_cnt_q <= '0;
            ovr_q     <= 1'b0;
        end else begin
            if (load) begin
                seq_cnt_q <= seq_cnt_q + 16'd1;
            end
            if (load && !stalled) begin
                valid_q <= 1'b1;
                data_q  <= frame_d;
                seq_q   <= seq_cnt_q;
            end else if (accept) begin
                valid_q <= 1'b0;
            end
            if (load && stalled) begin
                ovr_q <= 1'b1;
            end else if (i_overrun_clr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign o_ads_fsync   = (state_q == ST_FSYNC);
    assign o_busy        = (state_q != ST_IDLE);
    assign o_frame_data  = data_q;
    assign o_frame_valid = valid_q;
    assign o_frame_seq   = seq_q;
    assign o_overrun     = ovr_q;
    assign o_ads_mode    = P_ADS_MODE;
    assign o_ads_pwdn    = CH_EN;
    assign o_ads_format  = ADS_FORMAT;
    assign o_ads_test    = ADS_TEST;
    assign o_ads_sync_n  = ADS_SYNC_N;

endmodule

// File: tb/tb_ads127x_frame_reader.sv
// Scoreboard bench: default-parameter reader plus a 4ch/16b/div2 reader with two channels powered down.
module tb_ads127x_frame_reader;

    typedef struct {
        logic [191:0] data;
        logic [15:0]  seq;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst_n, start_a, ready_a, clr_a, start_b;
    logic         fsync_a, sclk_a, valid_a, ovr_a, busy_a, sync_a;
    logic [7:0]   adc_a, pwdn_a;
    logic [1:0]   mode_a, test_a;
    logic [2:0]   format_a;
    logic [191:0] data_a;
    logic [15:0]  seq_a;
    logic         fsync_b, sclk_b, valid_b, ovr_b, busy_b, sync_b;
    logic [3:0]   adc_b, pwdn_b;
    logic [1:0]   mode_b, test_b;
    logic [2:0]   format_b;
    logic [63:0]  data_b;
    logic [15:0]  seq_b;

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  fa = -1, bita = 0, fb = -1, bitb = 0;
    sb_t qa[$], qb[$];
    sb_t ea, eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ads127x_frame_reader dut_a (
        .i_sysclk(clk), .i_rst_n(rst_n), .i_start(start_a),
        .o_ads_fsync(fsync_a), .o_ads_sclk(sclk_a), .i_ads_data(adc_a),
        .o_ads_mode(mode_a), .o_ads_pwdn(pwdn_a), .o_ads_format(format_a),
        .o_ads_test(test_a), .o_ads_sync_n(sync_a),
        .o_frame_data(data_a), .o_frame_valid(valid_a), .i_frame_ready(ready_a),
        .o_frame_seq(seq_a), .o_overrun(ovr_a), .i_overrun_clr(clr_a), .o_busy(busy_a)
    );

    ads127x_frame_reader #(
        .P_CH_NUM(4), .P_DATA_W(16), .P_SCLK_DIV(2), .P_FRAME_CYC(64),
        .P_ADS_MODE(2'b01), .P_ADS_PWDN(8'b0000_0101)
    ) dut_b (
        .i_sysclk(clk), .i_rst_n(rst_n), .i_start(start_b),
        .o_ads_fsync(fsync_b), .o_ads_sclk(sclk_b), .i_ads_data(adc_b),
        .o_ads_mode(mode_b), .o_ads_pwdn(pwdn_b), .o_ads_format(format_b),
        .o_ads_test(test_b), .o_ads_sync_n(sync_b),
        .o_frame_data(data_b), .o_frame_valid(valid_b), .i_frame_ready(1'b1),
        .o_frame_seq(seq_b), .o_overrun(ovr_b), .i_overrun_clr(1'b0), .o_busy(busy_b)
    );

    function automatic logic [23:0] word_a(input int ch, input int f);
        return 24'hA5A5A0 + 24'(ch) + 24'(f) * 24'h010000;
    endfunction

    function automatic logic [15:0] word_b(input int ch, input int f);
        return 16'hA5A0 + 16'(ch) + 16'(f) * 16'h1000;
    endfunction

    function automatic logic [191:0] exp_a(input int f);
        logic [191:0] v;
        v = '0;
        for (int ch = 0; ch < 8; ch++) v[ch*24 +: 24] = word_a(ch, f);
        return v;
    endfunction

    function automatic logic [191:0] exp_b(input int f);
        logic [191:0] v;
        v = '0;
        v[0*16 +: 16] = word_b(0, f);
        v[2*16 +: 16] = word_b(2, f);
        return v;
    endfunction

    // ADC models: restart at FSYNC, advance one bit per SCLK falling edge, MSB first.
    always @(posedge fsync_a) begin fa = fa + 1; bita = 0; end
    always @(negedge sclk_a) bita = bita + 1;
    always @(posedge fsync_b) begin fb = fb + 1; bitb = 0; end
    always @(negedge sclk_b) bitb = bitb + 1;

    always_comb begin
        logic [23:0] wa;
        logic [15:0] wb;
        adc_a = '0;
        adc_b = '0;
        for (int ch = 0; ch < 8; ch++) begin
            wa = word_a(ch, fa);
            if (bita < 24) adc_a[ch] = wa[23 - bita];
        end
        for (int ch = 0; ch < 4; ch++) begin
            wb = word_b(ch, fb);
            if (bitb < 16) adc_b[ch] = wb[15 - bitb];
        end
    end

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && valid_a && ready_a) begin
            if (qa.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_a_unexpected actual=seq %0d required=no frame", seq_a);
            end else begin
                ea = qa.pop_front();
                check("sb_a_data", data_a, ea.data);
                check("sb_a_seq", seq_a, ea.seq);
            end
        end
        if (rst_n && valid_b) begin
            if (qb.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_b_unexpected actual=seq %0d required=no frame", seq_b);
            end else begin
                eb = qb.pop_front();
                check("sb_b_data", data_b, eb.data);
                check("sb_b_seq", seq_b, eb.seq);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return fsync_a;
            1:       return valid_a;
            2:       return fsync_b;
            default: return valid_b;
        endcase
    endfunction

    task automatic wait_rise(input int sel, output int c);
        logic prev, cur;
        prev = sig(sel);
        c = -1;
        for (int n = 0; n < 2000; n++) begin
            tick(1);
            cur = sig(sel);
            if (cur && !prev) begin
                c = cyc;
                break;
            end
            prev = cur;
        end
        if (c < 0) begin
            checks++; failures++;
            $display("FAIL timeout_sel%0d actual=no rise required=rise", sel);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, f0, f1, f2, v;
        int nvalid;
        rst_n = 1'b0; start_a = 1'b0; ready_a = 1'b0; clr_a = 1'b0; start_b = 1'b0;
        tick(3);
        check("rst_a_outs", {fsync_a, sclk_a, valid_a, ovr_a, busy_a}, 5'b0);
        check("rst_a_data_seq", {data_a, seq_a}, '0);
        check("rst_a_ties", {mode_a, pwdn_a, format_a, test_a, sync_a}, {2'b01, 8'hFF, 3'b101, 2'b00, 1'b1});
        check("rst_b_outs", {fsync_b, sclk_b, valid_b, ovr_b, busy_b, data_b, seq_b}, '0);
        check("rst_b_ties", {mode_b, pwdn_b, format_b, test_b, sync_b}, {2'b01, 4'b0101, 3'b101, 2'b00, 1'b1});
        rst_n = 1'b1;
        tick(2);

        // 1: free-running with ready high
        ready_a = 1'b1;
        for (int f = 0; f < 3; f++) qa.push_back('{exp_a(f), 16'(f)});
        s = cyc;
        start_a = 1'b1;
        wait_rise(0, f0);
        check("first_fsync_delay", 32'(f0 - s), 32'd513);
        wait_rise(1, v);
        check("valid_latency", 32'(v - f0), 32'd101);
        wait_rise(0, f1);
        check("fsync_period_1", 32'(f1 - f0), 32'd512);
        wait_rise(0, f2);
        check("fsync_period_2", 32'(f2 - f1), 32'd512);
        tick(110);
        check("t1_drained", 32'(qa.size()), 32'd0);

        // 2: consumer stalls across three frames
        ready_a = 1'b0;
        qa.push_back('{exp_a(3), 16'd3});
        wait_rise(0, f0);
        tick(102);
        check("stall_valid", valid_a, 1'b1);
        check("stall_ovr_before", ovr_a, 1'b0);
        wait_rise(0, f0);
        tick(100);
        check("ovr_in_load_cycle", ovr_a, 1'b0);
        tick(1);
        check("ovr_after_2nd_load", ovr_a, 1'b1);
        check("stall_data_2", data_a, exp_a(3));
        check("stall_seq_2", seq_a, 16'd3);
        wait_rise(0, f0);
        tick(102);
        check("stall_data_3", data_a, exp_a(3));
        check("stall_seq_3", seq_a, 16'd3);
        qa.push_back('{exp_a(6), 16'd6});
        ready_a = 1'b1;
        wait_rise(0, f0);
        tick(105);
        check("t2_drained", 32'(qa.size()), 32'd0);
        check("ovr_sticky", ovr_a, 1'b1);
        clr_a = 1'b1; tick(1); clr_a = 1'b0;
        check("ovr_clear", ovr_a, 1'b0);

        // 3: ready pulsed in the LOAD cycle, then clear colliding with overrun
        ready_a = 1'b0;
        qa.push_back('{exp_a(7), 16'd7});
        wait_rise(0, f0);
        tick(102);
        check("t3_held_valid", valid_a, 1'b1);
        qa.push_back('{exp_a(8), 16'd8});
        wait_rise(0, f0);
        tick(100);
        ready_a = 1'b1; tick(1); ready_a = 1'b0;
        check("load_accept_ovr", ovr_a, 1'b0);
        check("load_accept_valid", valid_a, 1'b1);
        check("load_accept_seq", seq_a, 16'd8);
        wait_rise(0, f0);
        tick(100);
        clr_a = 1'b1; tick(1); clr_a = 1'b0;
        check("clr_vs_ovr", ovr_a, 1'b1);
        clr_a = 1'b1; tick(1); clr_a = 1'b0;
        check("clr_alone", ovr_a, 1'b0);
        ready_a = 1'b1;
        tick(2);
        check("t3_drained", 32'(qa.size()), 32'd0);

        // 4: abort during bit 10 of SHIFT, then restart
        wait_rise(0, f0);
        tick(46);
        check("abort_sclk_high", sclk_a, 1'b1);
        start_a = 1'b0;
        tick(1);
        check("abort_pins", {sclk_a, fsync_a, busy_a}, 3'b000);
        nvalid = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (valid_a) nvalid++;
        end
        check("abort_no_valid", 32'(nvalid), 32'd0);
        qa.push_back('{exp_a(11), 16'd10});
        s = cyc;
        start_a = 1'b1;
        wait_rise(0, f0);
        check("restart_fsync_delay", 32'(f0 - s), 32'd513);
        wait_rise(1, v);
        check("restart_latency", 32'(v - f0), 32'd101);
        tick(5);
        check("t4_drained", 32'(qa.size()), 32'd0);

        // 5: asynchronous reset mid-SHIFT with a frame pending
        ready_a = 1'b0;
        wait_rise(0, f0);
        tick(102);
        check("pre_rst_valid", valid_a, 1'b1);
        wait_rise(0, f0);
        tick(30);
        #2 rst_n = 1'b0;
        #1;
        check("arst_outs", {fsync_a, sclk_a, valid_a, ovr_a, busy_a}, 5'b0);
        check("arst_data_seq", {data_a, seq_a}, '0);
        start_a = 1'b0;
        ready_a = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        qa.push_back('{exp_a(14), 16'd0});
        s = cyc;
        start_a = 1'b1;
        wait_rise(0, f0);
        check("post_rst_fsync_delay", 32'(f0 - s), 32'd513);
        tick(105);
        check("t5_drained", 32'(qa.size()), 32'd0);
        start_a = 1'b0;

        // 6: small configuration with channels 1 and 3 powered down
        qb.push_back('{exp_b(0), 16'd0});
        qb.push_back('{exp_b(1), 16'd1});
        start_b = 1'b1;
        wait_rise(2, f0);
        wait_rise(3, v);
        check("b_valid_latency", 32'(v - f0), 32'd35);
        wait_rise(2, f1);
        check("b_fsync_period", 32'(f1 - f0), 32'd64);
        tick(40);
        check("t6_drained", 32'(qb.size()), 32'd0);
        check("b_status", {ovr_b, busy_b}, 2'b01);
        start_b = 1'b0;

        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
